// File: rtl/sha3_rate_padder_pkg.sv
// Shared constants and FSM encoding for the SHA3 rate padder.
package sha3_rate_padder_pkg;

  // SHA3 domain-separation byte placed right after the message
  localparam logic [7:0] SHA3_DS_BYTE  = 8'h06;
  // Final padding bit, always in the last byte of the rate block
  localparam logic [7:0] SHA3_END_BYTE = 8'h80;

  localparam int RATE_512  = 576;
  localparam int W_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    PAD  = 3'd2,
    XPAD = 3'd3,
    EMIT = 3'd4
  } state_e;

endpackage

// File: rtl/sha3_rate_padder_if.sv
// Message-word input stream and rate-block output stream of the padder.
// The slave modport is the padder's view, master is the environment's view.
interface sha3_rate_padder_if
  import sha3_rate_padder_pkg::*;
#(
  parameter int W    = W_DEFAULT,
  parameter int RATE = RATE_512
);
  logic            in_valid;
  logic [W-1:0]    in_data;
  logic            in_last;
  logic [3:0]      in_bytes;
  logic            in_ready;
  logic            blk_valid;
  logic [RATE-1:0] blk_data;
  logic            blk_last;
  logic            blk_ready;
  logic            busy;

  modport master (
    output in_valid, in_data, in_last, in_bytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last, busy
  );
endinterface

// File: rtl/sha3_rate_padder_pad_mask.sv
// Combinational keep-mask and pad-pattern generator. Given the byte index p
// where the message ends inside the block, bytes below p are kept and the
// pattern carries 0x06 at byte p and 0x80 in the final byte. When p equals
// the block size the message fills the block, so everything is kept and no
// pattern is produced (the padding goes into an extra block).
module sha3_pad_mask
  import sha3_rate_padder_pkg::*;
#(
  parameter int RATE = RATE_512,
  parameter int PW   = 7
) (
  input  logic [PW-1:0]   p,
  output logic [RATE-1:0] keep,
  output logic [RATE-1:0] pat
);
  localparam int NB = RATE / 8;

  // Per-byte keep mask and padding pattern derived from the end position
  always_comb begin
    keep = '0;
    pat  = '0;
    for (int i = 0; i < NB; i++) begin
      if (PW'(i) < p) keep[8*i +: 8] = 8'hFF;
      else            keep[8*i +: 8] = 8'h00;
      if (PW'(i) == p) pat[8*i +: 8] = SHA3_DS_BYTE;
      else             pat[8*i +: 8] = 8'h00;
    end
    if (p < PW'(NB)) pat[RATE-8 +: 8] = pat[RATE-8 +: 8] | SHA3_END_BYTE;
    else             pat[RATE-8 +: 8] = pat[RATE-8 +: 8];
  end
endmodule

// File: rtl/sha3_rate_padder.sv
// SHA3 rate padder: packs 64-bit message words into rate blocks, applies
// 0x06..0x80 domain padding and hands blocks to the keccak absorb port.
module sha3_rate_padder
  import sha3_rate_padder_pkg::*;
#(
  parameter int W    = W_DEFAULT,
  parameter int RATE = RATE_512
) (
  input  logic              clk,
  input  logic              rst_b,
  sha3_rate_padder_if.slave bus
);
  localparam int NW = RATE / W;
  localparam int NB = RATE / 8;
  localparam int WB = W / 8;
  localparam int PW = $clog2(NB + 1);
  localparam int CW = $clog2(NW + 1);
  localparam logic [3:0] WB_MAX = 4'(WB);

  state_e          state_r;
  logic [CW-1:0]   cnt_r;
  logic [PW-1:0]   p_r;
  logic            xpad_r;
  logic            in_ready_r;
  logic            blk_valid_r;
  logic            blk_last_r;
  logic            busy_r;
  logic [RATE-1:0] blk_data_r;

  logic            accept_s;
  logic            last_slot_s;
  logic [3:0]      nb_s;
  logic [W-1:0]    word_s;
  logic [PW-1:0]   p_in_s;
  logic [PW-1:0]   p_sel_s;
  logic [RATE-1:0] keep_s;
  logic [RATE-1:0] pat_s;

  assign bus.in_ready  = in_ready_r;
  assign bus.blk_valid = blk_valid_r;
  assign bus.blk_last  = blk_last_r;
  assign bus.blk_data  = blk_data_r;
  assign bus.busy      = busy_r;

  assign accept_s    = bus.in_valid & in_ready_r;
  assign last_slot_s = (cnt_r == CW'(NW - 1));

  // Clamp the byte count of a last word to the word size
  always_comb begin
    if (bus.in_bytes > WB_MAX) nb_s = WB_MAX;
    else                       nb_s = bus.in_bytes;
  end

  // Zero the bytes of a last word that lie past the message end
  always_comb begin
    word_s = bus.in_data;
    for (int j = 0; j < WB; j++) begin
      if (bus.in_last && (4'(j) >= nb_s)) word_s[8*j +: 8] = 8'h00;
      else                                word_s[8*j +: 8] = bus.in_data[8*j +: 8];
    end
  end

  // Message end position in bytes, and the mask position used by PAD/XPAD
  always_comb begin
    p_in_s = PW'(cnt_r) * PW'(WB) + PW'(nb_s);
    if (state_r == XPAD) p_sel_s = {PW{1'b0}};
    else                 p_sel_s = p_r;
  end

  sha3_pad_mask #(
    .RATE (RATE),
    .PW   (PW)
  ) u_pad_mask (
    .p    (p_sel_s),
    .keep (keep_s),
    .pat  (pat_s)
  );

  // Main FSM: fill word slots, pad, and emit blocks with registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      p_r         <= '0;
      xpad_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      blk_valid_r <= 1'b0;
      blk_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      blk_data_r  <= '0;
    end else begin
      case (state_r)
        IDLE, FILL: begin
          in_ready_r <= 1'b1;
          if (accept_s) begin
            blk_data_r[int'(cnt_r)*W +: W] <= word_s;
            busy_r <= 1'b1;
            if (bus.in_last) begin
              p_r        <= p_in_s;
              in_ready_r <= 1'b0;
              state_r    <= PAD;
            end else if (last_slot_s) begin
              cnt_r       <= CW'(NW);
              in_ready_r  <= 1'b0;
              blk_valid_r <= 1'b1;
              blk_last_r  <= 1'b0;
              state_r     <= EMIT;
            end else begin
              cnt_r   <= cnt_r + CW'(1);
              state_r <= FILL;
            end
          end else begin
            state_r <= state_r;
          end
        end
        PAD: begin
          blk_data_r  <= (blk_data_r & keep_s) | pat_s;
          blk_valid_r <= 1'b1;
          state_r     <= EMIT;
          // A message ending exactly on the block boundary needs an extra pad block
          if (p_r == PW'(NB)) begin
            blk_last_r <= 1'b0;
            xpad_r     <= 1'b1;
          end else begin
            blk_last_r <= 1'b1;
            xpad_r     <= 1'b0;
          end
        end
        XPAD: begin
          // keep_s is all-zero here, so this builds the bare 0x06..0x80 block
          blk_data_r  <= (blk_data_r & keep_s) | pat_s;
          blk_valid_r <= 1'b1;
          blk_last_r  <= 1'b1;
          xpad_r      <= 1'b0;
          state_r     <= EMIT;
        end
        EMIT: begin
          if (blk_valid_r && bus.blk_ready) begin
            blk_valid_r <= 1'b0;
            cnt_r       <= '0;
            if (blk_last_r) begin
              busy_r     <= 1'b0;
              in_ready_r <= 1'b1;
              state_r    <= IDLE;
            end else if (xpad_r) begin
              state_r <= XPAD;
            end else begin
              in_ready_r <= 1'b1;
              state_r    <= FILL;
            end
          end else begin
            state_r <= EMIT;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= '0;
          xpad_r      <= 1'b0;
          in_ready_r  <= 1'b0;
          blk_valid_r <= 1'b0;
          blk_last_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha3_rate_padder.sv
// Self-checking bench for sha3_rate_padder with a byte-level SHA3 pad model.
module tb_sha3_rate_padder;
  localparam int W    = 64;
  localparam int RATE = 576;
  localparam int NB   = RATE / 8;
  localparam int NW   = RATE / W;

  typedef byte unsigned bq_t[$];

  logic clk;
  logic rst_b;
  int   errors;
  int   checks;

  logic [RATE-1:0] exp_data[$];
  bit              exp_last[$];
  logic [RATE-1:0] got_data[$];
  bit              got_last[$];

  sha3_rate_padder_if #(.W(W), .RATE(RATE)) bus();

  sha3_rate_padder #(.W(W), .RATE(RATE)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: append 0x06, zero-fill to a multiple of the rate, OR 0x80 into the last byte
  task automatic build_exp(input bq_t msg);
    int L;
    int tot;
    byte unsigned pb[$];
    logic [RATE-1:0] d;
    L = msg.size();
    tot = ((L + 1 + NB - 1) / NB) * NB;
    pb = msg;
    while (pb.size() < tot) pb.push_back(8'h00);
    pb[L] = pb[L] | 8'h06;
    pb[tot-1] = pb[tot-1] | 8'h80;
    exp_data.delete();
    exp_last.delete();
    for (int b = 0; b < tot / NB; b++) begin
      for (int i = 0; i < NB; i++) d[8*i +: 8] = pb[b*NB + i];
      exp_data.push_back(d);
      exp_last.push_back(b == tot / NB - 1);
    end
  endtask

  // Drive one message with random valid/ready duty and check every block
  task automatic run_msg(input bq_t msg, input int vpct, input int rpct);
    int len, nwords, lastb, wi, bi, cyc, exp_at, zero_at;
    logic [W-1:0] w;
    logic [RATE-1:0] prev;
    bit prev_last, prev_hold;
    len = msg.size();
    build_exp(msg);
    got_data.delete();
    got_last.delete();
    nwords = (len == 0) ? 1 : (len + 7) / 8;
    lastb = len - 8 * (nwords - 1);
    wi = 0; bi = 0; cyc = 0; exp_at = -1; zero_at = -1; prev_hold = 0;
    prev = '0; prev_last = 0;
    while (bi < exp_data.size() && cyc < 2000) begin
      if (wi < nwords && $urandom_range(99) < vpct) begin
        w = {$urandom, $urandom};
        for (int j = 0; j < 8; j++)
          if (wi*8 + j < len) w[8*j +: 8] = msg[wi*8 + j];
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        bus.in_last  = (wi == nwords - 1);
        if (wi != nwords - 1)
          bus.in_bytes = 4'($urandom_range(15));
        else if (lastb == 8 && $urandom_range(1) == 1)
          bus.in_bytes = 4'($urandom_range(15, 8));
        else
          bus.in_bytes = 4'(lastb);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom};
        bus.in_last  = 1'($urandom);
        bus.in_bytes = 4'($urandom);
      end
      bus.blk_ready = ($urandom_range(99) < rpct);
      if (cyc == zero_at) begin
        checks++;
        if (bus.blk_valid !== 1'b0) begin
          errors++;
          $display("FAIL pad_stage: blk_valid got %b want 0", bus.blk_valid);
        end
      end
      if (cyc == exp_at) begin
        checks++;
        if (bus.blk_valid !== 1'b1) begin
          errors++;
          $display("FAIL latency: blk_valid got %b want 1 (cycle %0d)", bus.blk_valid, cyc);
        end
      end
      if (prev_hold && bus.blk_valid) begin
        checks++;
        if (bus.blk_data !== prev || bus.blk_last !== prev_last) begin
          errors++;
          $display("FAIL hold_stable: blk_data/blk_last changed while stalled, got last %b want %b", bus.blk_last, prev_last);
        end
      end
      if (bus.blk_valid) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_in_emit: in_ready got %b want 0", bus.in_ready);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (bus.in_last) begin
          zero_at = cyc + 1;
          exp_at  = cyc + 2;
        end else if (wi % NW == NW - 1) begin
          exp_at = cyc + 1;
        end
        wi++;
      end
      if (bus.blk_valid && bus.blk_ready) begin
        got_data.push_back(bus.blk_data);
        got_last.push_back(bus.blk_last);
        checks++;
        if (bus.blk_data !== exp_data[bi]) begin
          errors++;
          $display("FAIL blk_data[%0d]: got %h want %h", bi, bus.blk_data, exp_data[bi]);
        end
        checks++;
        if (bus.blk_last !== exp_last[bi]) begin
          errors++;
          $display("FAIL blk_last[%0d]: got %b want %b", bi, bus.blk_last, exp_last[bi]);
        end
        bi++;
        prev_hold = 0;
      end else begin
        prev_hold = bus.blk_valid;
        prev      = bus.blk_data;
        prev_last = bus.blk_last;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.blk_ready = 1'b0;
    checks++;
    if (bi < exp_data.size()) begin
      errors++;
      $display("FAIL msg_timeout: blocks got %0d want %0d", bi, exp_data.size());
    end else if (bus.busy !== 1'b0 || bus.blk_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL msg_done: busy/blk_valid/in_ready got %b%b%b want 001", bus.busy, bus.blk_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.in_bytes = 4'd0; bus.blk_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.blk_valid !== 1'b0 || bus.blk_last !== 1'b0 ||
        bus.busy !== 1'b0 || bus.blk_data !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy/vld/last/busy got %b%b%b%b want 0000", bus.in_ready, bus.blk_valid, bus.blk_last, bus.busy);
    end
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_empty();
    bq_t m;
    logic [RATE-1:0] c;
    m.delete();
    run_msg(m, 100, 100);
    c = '0; c[7:0] = 8'h06; c[RATE-1 -: 8] = 8'h80;
    checks++;
    if (got_data.size() != 1 || got_data[0] !== c || got_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL empty_block: got %0d blocks, data %h want %h", got_data.size(), (got_data.size() > 0) ? got_data[0] : '0, c);
    end
  endtask

  task automatic test_abc();
    bq_t m;
    logic [RATE-1:0] c;
    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m, 100, 100);
    c = '0; c[23:0] = 24'h636261; c[31:24] = 8'h06; c[RATE-1 -: 8] = 8'h80;
    checks++;
    if (got_data.size() != 1 || got_data[0] !== c) begin
      errors++;
      $display("FAIL abc_block: got %0d blocks, data %h want %h", got_data.size(), (got_data.size() > 0) ? got_data[0] : '0, c);
    end
  endtask

  task automatic test_71_bytes();
    bq_t m;
    m.delete();
    for (int i = 0; i < 71; i++) m.push_back(8'($urandom));
    run_msg(m, 100, 100);
    checks++;
    if (got_data.size() != 1 || got_data[0][RATE-1 -: 8] !== 8'h86 || got_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL byte71_0x86: got %0d blocks, byte71 %h want 86", got_data.size(), (got_data.size() > 0) ? got_data[0][RATE-1 -: 8] : 8'h00);
    end
  endtask

  task automatic test_72_bytes();
    bq_t m;
    logic [RATE-1:0] c;
    m.delete();
    for (int i = 0; i < 72; i++) m.push_back(8'($urandom));
    run_msg(m, 100, 100);
    c = '0; c[7:0] = 8'h06; c[RATE-1 -: 8] = 8'h80;
    checks++;
    if (got_data.size() != 2 || got_last[0] !== 1'b0 || got_data[1] !== c || got_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL boundary_xpad: got %0d blocks, second %h want %h", got_data.size(), (got_data.size() > 1) ? got_data[1] : '0, c);
    end
  endtask

  task automatic test_random();
    bq_t m;
    for (int n = 0; n < 30; n++) begin
      m.delete();
      for (int i = 0; i < int'($urandom_range(200)); i++) m.push_back(8'($urandom));
      run_msg(m, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)));
    end
  endtask

  task automatic test_backpressure();
    bq_t m;
    int wi, t;
    m.delete();
    for (int i = 0; i < 16; i++) m.push_back(8'($urandom));
    build_exp(m);
    bus.blk_ready = 1'b0;
    wi = 0; t = 0;
    while (wi < 2 && t < 50) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {m[wi*8+7], m[wi*8+6], m[wi*8+5], m[wi*8+4], m[wi*8+3], m[wi*8+2], m[wi*8+1], m[wi*8]};
      bus.in_last  = (wi == 1);
      bus.in_bytes = 4'd8;
      if (bus.in_ready) wi++;
      @(posedge clk); @(negedge clk); t++;
    end
    bus.in_valid = 1'b0;
    t = 0;
    while (!bus.blk_valid && t < 10) begin
      @(posedge clk); @(negedge clk); t++;
    end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (bus.blk_valid !== 1'b1 || bus.blk_data !== exp_data[0] || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld %b rdy %b data %h want %h", k, bus.blk_valid, bus.in_ready, bus.blk_data, exp_data[0]);
      end
      @(posedge clk); @(negedge clk);
    end
    bus.blk_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.blk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: vld/busy/rdy got %b%b%b want 001", bus.blk_valid, bus.busy, bus.in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.blk_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_once: blk_valid got %b want 0", bus.blk_valid);
      end
    end
    bus.blk_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    bq_t m;
    int wi, t;
    wi = 0; t = 0;
    while (wi < 4 && t < 50) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {$urandom, $urandom};
      bus.in_last  = 1'b0;
      bus.in_bytes = 4'd8;
      if (bus.in_ready) wi++;
      @(posedge clk); @(negedge clk); t++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL fill_busy: busy got %b want 1", bus.busy);
    end
    @(posedge clk);
    #3 rst_b = 1'b0;
    #1;
    checks++;
    if (bus.blk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.blk_data !== '0) begin
      errors++;
      $display("FAIL rst_fill: vld/busy/rdy got %b%b%b want 000", bus.blk_valid, bus.busy, bus.in_ready);
    end
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    m.delete();
    run_msg(m, 100, 100);
    // Park an empty-message block in EMIT, then reset: blk_valid must drop at once
    bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.in_bytes = 4'd0; bus.blk_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    t = 0;
    while (!bus.blk_valid && t < 10) begin
      @(posedge clk); @(negedge clk); t++;
    end
    @(posedge clk);
    #3 rst_b = 1'b0;
    #1;
    checks++;
    if (bus.blk_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_emit: vld/busy got %b%b want 00", bus.blk_valid, bus.busy);
    end
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    run_msg(m, 100, 100);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_empty();
    test_abc();
    test_71_bytes();
    test_72_bytes();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
